barrel_shift_feeder: RTL and testbench
======================================

# barrel_shift_feeder

Command-buffering issue stage that sits directly upstream of the 8-bit barrel shifter (`barrel_8_bit`) and captures its result. Shift commands (data, amount, direction) arrive on a valid/ready interface and are queued in a small FIFO. They are issued one per cycle as registered drive into the shifter's `in`/`n`/`lr` inputs. The shifter's combinational `out` is registered into a result slot with its own valid/ready handshake, so the block provides full-throughput, backpressure-aware sequencing around the purely combinational shifter.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, 2..16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_vld` input 1: command valid.
- `cmd_rdy` output 1: FIFO can accept a command.
- `cmd_data` input 8: value to shift.
- `cmd_n` input 3: shift amount, 0..7.
- `cmd_lr` input 1: direction bit, passed unchanged to the shifter's `lr`.
- `sh_in` output 8: registered drive to shifter `in`.
- `sh_n` output 3: registered drive to shifter `n`.
- `sh_lr` output 1: registered drive to shifter `lr`.
- `sh_vld` output 1: issue register holds a live command.
- `sh_out` input 8: shifter `out`, combinational from `sh_in`/`sh_n`/`sh_lr`.
- `res_vld` output 1: result slot full.
- `res_rdy` input 1: consumer accepts result.
- `res_data` output 8: captured shifter result.
- `occ` output $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Push: on an edge with `cmd_vld && cmd_rdy`, `{cmd_data, cmd_n, cmd_lr}` is written at the write pointer and the pointer advances modulo DEPTH.
- `cmd_rdy = (occ != DEPTH)`. This is a pure function of occupancy. No push is allowed when full, even if a pop happens in the same cycle.
- `res_free = !res_vld || res_rdy`.
- `adv = !sh_vld || res_free`. The issue register may load or clear only when `adv` is high.
- Issue: on an edge with `adv`:
  - FIFO non-empty: pop the head into `sh_in`/`sh_n`/`sh_lr` and set `sh_vld=1`.
  - FIFO empty: clear `sh_vld` to 0. The data fields hold their last value.
- Capture: on an edge with `sh_vld && res_free`, `res_data <= sh_out` and `res_vld <= 1`.
  - Otherwise, on an edge with `res_vld && res_rdy`, `res_vld <= 0`.
- Stall: while `res_vld && !res_rdy`, the following are all frozen: issue register, FIFO head, and `res_data`. The FIFO can still accept pushes until full.
- Simultaneous push and pop: `occ` is unchanged. A push into an empty FIFO is not bypassed; it becomes poppable on the next edge.
- Pointers wrap modulo DEPTH. `occ` ranges 0..DEPTH and never overflows or underflows.
- Ordering: results leave in exactly the order commands were accepted, with no drops or duplicates.
- Reset (asserted at any time, including mid-stream): all queued, issued and captured commands are discarded. Output values:
  - `occ=0`, `cmd_rdy=1`
  - `sh_vld=0`, `sh_in=0`, `sh_n=0`, `sh_lr=0`
  - `res_vld=0`, `res_data=0`
  - pointers 0

## Timing
- Latency: a command accepted at edge E drives `sh_*` with `sh_vld=1` after edge E+1. `res_vld=1` with its result follows after edge E+2. This holds when there is no backpressure and the FIFO was empty.
- Throughput: one command per cycle sustained while `res_rdy=1`.
- `sh_out` is sampled in the same cycle `sh_*` is driven. The shifter must settle within one clock period.
- All outputs are registered except `cmd_rdy`, which is decoded from the `occ` register. There are no combinational paths from `res_rdy` or `cmd_vld` to any output.
- Buffering is DEPTH + 2 commands in flight: FIFO, issue register, result slot.

## Test plan
- Single command: `cmd_data=8'h01`, `cmd_n=3`, `cmd_lr=1`, `res_rdy=1`. Required: `sh_in=01`/`sh_n=3`/`sh_lr=1` with `sh_vld=1` one cycle after acceptance. The next cycle has `res_vld=1` and `res_data` equal to the shifter's output for that input; check `8'h08` if `lr=1` is left.
- Back-to-back stream: 20 commands on consecutive cycles with `res_rdy=1`. Required: `res_vld` high on 20 consecutive cycles, in-order results matching the reference model, and `cmd_rdy` never low.
- Backpressure fill: `res_rdy=0` while pushing 8 commands with DEPTH=4. Required:
  - `cmd_rdy` drops after 6 accepts (one captured, one issued, four queued).
  - `occ=4`.
  - `res_data` stays stable.
- Drain: from the full state, raise `res_rdy`. Required: all 6 buffered results are delivered in order, then `res_vld=0`, `sh_vld=0`, `occ=0`. The 2 rejected commands are never observed.
- Wrap and simultaneous push/pop: alternate `res_rdy` 1/0 for 3·DEPTH cycles with continuous pushes. Required: `occ` never exceeds DEPTH, results stay in order, and `occ` is unchanged on cycles with both a push and a pop.
- Reset mid-stream: assert `rst_n=0` for 1 cycle with `occ=3`, `sh_vld=1`, `res_vld=1`. Required: every output is at its reset value immediately, without waiting for `clk`. After release, a new command yields a correct result with E+2 latency.

Source files
------------

// File: rtl/barrel_shift_feeder.sv
// barrel_shift_feeder: queues shift commands and issues them one per cycle
// into an external combinational 8-bit barrel shifter. It captures the
// shifter output into a result slot with valid/ready backpressure.
// Pipeline: command FIFO -> issue register (drives shifter) -> result slot.
module barrel_shift_feeder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // command input
    input  logic                     cmd_vld_i,
    output logic                     cmd_rdy_o,
    input  logic [7:0]               cmd_data_i,
    input  logic [2:0]               cmd_n_i,
    input  logic                     cmd_lr_i,
    // registered drive into the shifter and its combinational result
    output logic [7:0]               sh_in_o,
    output logic [2:0]               sh_n_o,
    output logic                     sh_lr_o,
    output logic                     sh_vld_o,
    input  logic [7:0]               sh_out_i,
    // result output
    output logic                     res_vld_o,
    input  logic                     res_rdy_i,
    output logic [7:0]               res_data_o,
    // FIFO occupancy
    output logic [$clog2(DEPTH):0]   occ_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = PtrW + 1;
    localparam int unsigned EntW = 12;
    localparam logic [OccW-1:0] OccFull = OccW'(DEPTH);

    // FIFO storage and bookkeeping
    logic [EntW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0] occ_q, occ_d;

    // issue register
    logic [7:0]      sh_in_q, sh_in_d;
    logic [2:0]      sh_n_q, sh_n_d;
    logic            sh_lr_q, sh_lr_d;
    logic            sh_vld_q, sh_vld_d;

    // result slot
    logic [7:0]      res_data_q, res_data_d;
    logic            res_vld_q, res_vld_d;

    // handshake decode
    logic            cmd_rdy;
    logic            push;
    logic            pop;
    logic            res_free;
    logic            adv;
    logic            fifo_empty;
    logic [EntW-1:0] head;

    // Handshake and advance conditions; cmd_rdy depends only on the occ register.
    always_comb begin
        cmd_rdy    = (occ_q != OccFull);
        push       = cmd_vld_i && cmd_rdy;
        res_free   = !res_vld_q || res_rdy_i;
        adv        = !sh_vld_q || res_free;
        fifo_empty = (occ_q == '0);
        pop        = adv && !fifo_empty;
        head       = mem_q[rd_ptr_q];
    end

    // FIFO pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^PtrW).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Issue register next-state: load the FIFO head or go idle, only when the slot can advance.
    always_comb begin
        sh_in_d  = sh_in_q;
        sh_n_d   = sh_n_q;
        sh_lr_d  = sh_lr_q;
        sh_vld_d = sh_vld_q;
        if (adv) begin
            if (!fifo_empty) begin
                {sh_in_d, sh_n_d, sh_lr_d} = head;
                sh_vld_d                   = 1'b1;
            end else begin
                // data fields keep their last value while idle
                sh_vld_d = 1'b0;
            end
        end
    end

    // Result slot next-state: capture the shifter output or retire the held result.
    always_comb begin
        res_data_d = res_data_q;
        res_vld_d  = res_vld_q;
        if (sh_vld_q && res_free) begin
            res_data_d = sh_out_i;
            res_vld_d  = 1'b1;
        end else if (res_vld_q && res_rdy_i) begin
            res_vld_d = 1'b0;
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_data_i, cmd_n_i, cmd_lr_i};
        end
    end

    // FIFO control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Issue register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_in_q  <= '0;
            sh_n_q   <= '0;
            sh_lr_q  <= 1'b0;
            sh_vld_q <= 1'b0;
        end else begin
            sh_in_q  <= sh_in_d;
            sh_n_q   <= sh_n_d;
            sh_lr_q  <= sh_lr_d;
            sh_vld_q <= sh_vld_d;
        end
    end

    // Result slot state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_q <= '0;
            res_vld_q  <= 1'b0;
        end else begin
            res_data_q <= res_data_d;
            res_vld_q  <= res_vld_d;
        end
    end

    assign cmd_rdy_o  = cmd_rdy;
    assign sh_in_o    = sh_in_q;
    assign sh_n_o     = sh_n_q;
    assign sh_lr_o    = sh_lr_q;
    assign sh_vld_o   = sh_vld_q;
    assign res_data_o = res_data_q;
    assign res_vld_o  = res_vld_q;
    assign occ_o      = occ_q;

    // Occupancy never exceeds the FIFO size, and always matches the pointer distance.
    occ_bound_a: assert property (@(posedge clk) disable iff (!rst_n) occ_q <= OccFull);
    ptr_occ_a: assert property (@(posedge clk) disable iff (!rst_n)
        (wr_ptr_q - rd_ptr_q) == occ_q[PtrW-1:0]);

endmodule

// File: tb/tb_barrel_shift_feeder.sv
// Self-checking bench for barrel_shift_feeder with a behavioural shifter stub.
// Every task starts and ends on a falling clock edge.
module tb_barrel_shift_feeder;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_vld;
    logic       cmd_rdy;
    logic [7:0] cmd_data;
    logic [2:0] cmd_n;
    logic       cmd_lr;
    logic [7:0] sh_in;
    logic [2:0] sh_n;
    logic       sh_lr;
    logic       sh_vld;
    logic [7:0] sh_out;
    logic       res_vld;
    logic       res_rdy;
    logic [7:0] res_data;
    logic [2:0] occ;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    // shifter stub: lr=1 shifts left, lr=0 shifts right (logical)
    assign sh_out = sh_lr ? (sh_in << sh_n) : (sh_in >> sh_n);

    barrel_shift_feeder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_vld_i  (cmd_vld),
        .cmd_rdy_o  (cmd_rdy),
        .cmd_data_i (cmd_data),
        .cmd_n_i    (cmd_n),
        .cmd_lr_i   (cmd_lr),
        .sh_in_o    (sh_in),
        .sh_n_o     (sh_n),
        .sh_lr_o    (sh_lr),
        .sh_vld_o   (sh_vld),
        .sh_out_i   (sh_out),
        .res_vld_o  (res_vld),
        .res_rdy_i  (res_rdy),
        .res_data_o (res_data),
        .occ_o      (occ)
    );

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] n,
                                             input logic lr);
        logic [7:0] r;
        r = d;
        for (int i = 0; i < int'(n); i++) begin
            r = lr ? {r[6:0], 1'b0} : {1'b0, r[7:1]};
        end
        return r;
    endfunction

    // packed snapshot of every output: occ, cmd_rdy, sh_vld, sh_in, sh_n, sh_lr, res_vld, res_data
    function automatic logic [25:0] outs();
        return {occ, cmd_rdy, sh_vld, sh_in, sh_n, sh_lr, res_vld, res_data};
    endfunction

    localparam logic [25:0] RstOuts = {3'd0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00};

    task automatic rand_cmd();
        cmd_data = 8'($urandom);
        cmd_n    = 3'($urandom_range(0, 7));
        cmd_lr   = 1'($urandom_range(0, 1));
    endtask

    // record the expected result of a command that will be accepted at the next edge
    task automatic note_push();
        if (cmd_vld && cmd_rdy) exp_q.push_back(ref_shift(cmd_data, cmd_n, cmd_lr));
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (outs() !== RstOuts) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", outs(), RstOuts);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        res_rdy  = 1'b1;
        cmd_vld  = 1'b1;
        cmd_data = 8'h01;
        cmd_n    = 3'd3;
        cmd_lr   = 1'b1;
        n_cmp++;
        if (cmd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_cmd_rdy: got %b expected 1", cmd_rdy);
        end
        @(negedge clk);  // after E
        cmd_vld = 1'b0;
        n_cmp++;
        if ({sh_vld, occ} !== {1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL single_after_E: sh_vld/occ got %b/%0d expected 0/1", sh_vld, occ);
        end
        @(negedge clk);  // after E+1
        n_cmp++;
        if ({sh_vld, sh_in, sh_n, sh_lr, res_vld} !== {1'b1, 8'h01, 3'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_issue: got vld=%b in=%h n=%0d lr=%b res_vld=%b expected 1 01 3 1 0",
                     sh_vld, sh_in, sh_n, sh_lr, res_vld);
        end
        @(negedge clk);  // after E+2
        n_cmp++;
        if ({res_vld, res_data} !== {1'b1, 8'h08}) begin
            n_fail++;
            $display("FAIL single_result: got vld=%b data=%h expected 1 08", res_vld, res_data);
        end
        @(negedge clk);
        n_cmp++;
        if ({res_vld, sh_vld, occ} !== {1'b0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL single_idle: got res_vld=%b sh_vld=%b occ=%0d expected 0 0 0",
                     res_vld, sh_vld, occ);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, run = 0, max_run = 0, rdy_low = 0;
        logic [7:0] exp;
        for (int c = 0; c < 30; c++) begin
            run = res_vld ? run + 1 : 0;
            if (run > max_run) max_run = run;
            res_rdy = 1'b1;
            if (res_vld && res_rdy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_result: got %h with nothing outstanding", res_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (res_data !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_result: got %h expected %h", res_data, exp);
                    end
                end
            end
            if (sent < 20) begin
                if (!cmd_rdy) rdy_low++;
                cmd_vld = 1'b1;
                rand_cmd();
                note_push();
                if (cmd_rdy) sent++;
            end else begin
                cmd_vld = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (max_run != 20 || rdy_low != 0 || sent != 20 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_stream: run=%0d rdy_low=%0d sent=%0d left=%0d expected 20 0 20 0",
                     max_run, rdy_low, sent, exp_q.size());
        end
    endtask

    task automatic test_backpressure_fill();
        int accepted = 0, first_low = -1, unstable = 0;
        logic held_vld = 1'b0;
        logic [7:0] held = '0;
        for (int a = 0; a < 8; a++) begin
            if (!cmd_rdy && first_low < 0) first_low = accepted;
            if (res_vld) begin
                if (!held_vld) begin
                    held     = res_data;
                    held_vld = 1'b1;
                end else if (res_data !== held) begin
                    unstable++;
                end
            end
            res_rdy = 1'b0;
            cmd_vld = 1'b1;
            rand_cmd();
            note_push();
            if (cmd_rdy) accepted++;
            @(negedge clk);
        end
        cmd_vld = 1'b0;
        n_cmp++;
        if (accepted != 6 || first_low != 6) begin
            n_fail++;
            $display("FAIL fill_accepts: got accepted=%0d low_after=%0d expected 6 6",
                     accepted, first_low);
        end
        n_cmp++;
        if ({occ, cmd_rdy, sh_vld, res_vld} !== {3'd4, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL fill_state: got occ=%0d rdy=%b sh_vld=%b res_vld=%b expected 4 0 1 1",
                     occ, cmd_rdy, sh_vld, res_vld);
        end
        n_cmp++;
        if (unstable != 0 || !held_vld || res_data !== held || exp_q.size() == 0 ||
            res_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL fill_res_stable: got %h unstable=%0d expected %h stable",
                     res_data, unstable, (exp_q.size() != 0) ? exp_q[0] : 8'hxx);
        end
    endtask

    task automatic test_drain();
        int delivered = 0;
        logic [7:0] exp;
        cmd_vld = 1'b0;
        for (int c = 0; c < 16; c++) begin
            res_rdy = 1'b1;
            if (res_vld && res_rdy) begin
                delivered++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL drain_result: got %h with nothing outstanding", res_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (res_data !== exp) begin
                        n_fail++;
                        $display("FAIL drain_result: got %h expected %h", res_data, exp);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (delivered != 6 || {res_vld, sh_vld, occ} !== {1'b0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL drain_end: got n=%0d res_vld=%b sh_vld=%b occ=%0d expected 6 0 0 0",
                     delivered, res_vld, sh_vld, occ);
        end
    endtask

    task automatic test_wrap();
        int occ_pred = 0, both = 0, bad_bound = 0, bad_occ = 0;
        logic push_now, pop_now;
        logic [7:0] exp;
        for (int c = 0; c < 3 * DEPTH + 1; c++) begin
            if (int'(occ) > DEPTH) bad_bound++;
            if (c > 0 && int'(occ) != occ_pred) begin
                bad_occ++;
                $display("FAIL wrap_occ: cycle %0d got %0d expected %0d", c, occ, occ_pred);
            end
            if (c == 3 * DEPTH) break;
            res_rdy = (c % 2 == 0);
            cmd_vld = 1'b1;
            rand_cmd();
            if (res_vld && res_rdy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wrap_result: got %h with nothing outstanding", res_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (res_data !== exp) begin
                        n_fail++;
                        $display("FAIL wrap_result: got %h expected %h", res_data, exp);
                    end
                end
            end
            push_now = cmd_rdy;
            pop_now  = (!sh_vld || !res_vld || res_rdy) && (occ != 0);
            if (push_now && pop_now) both++;
            occ_pred = int'(occ) + int'(push_now) - int'(pop_now);
            note_push();
            @(negedge clk);
        end
        n_cmp++;
        if (bad_occ != 0 || bad_bound != 0 || both == 0) begin
            n_fail++;
            $display("FAIL wrap_occupancy: got bad=%0d over=%0d both=%0d expected 0 0 >0",
                     bad_occ, bad_bound, both);
        end
        cmd_vld = 1'b0;
        for (int c = 0; c < 20; c++) begin
            res_rdy = 1'b1;
            if (res_vld) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wrap_drain: got %h with nothing outstanding", res_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (res_data !== exp) begin
                        n_fail++;
                        $display("FAIL wrap_drain: got %h expected %h", res_data, exp);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (exp_q.size() != 0 || occ !== 3'd0 || res_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_end: got left=%0d occ=%0d res_vld=%b expected 0 0 0",
                     exp_q.size(), occ, res_vld);
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] exp;
        res_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_vld = 1'b1;
            rand_cmd();
            note_push();
            @(negedge clk);
        end
        cmd_vld = 1'b0;
        n_cmp++;
        if ({occ, sh_vld, res_vld} !== {3'd3, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_pre: got occ=%0d sh_vld=%b res_vld=%b expected 3 1 1",
                     occ, sh_vld, res_vld);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== RstOuts) begin
            n_fail++;
            $display("FAIL midrst_async: got %h expected %h", outs(), RstOuts);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        res_rdy  = 1'b1;
        cmd_vld  = 1'b1;
        cmd_data = 8'hA5;
        cmd_n    = 3'd2;
        cmd_lr   = 1'b0;
        note_push();
        @(negedge clk);  // after E
        cmd_vld = 1'b0;
        n_cmp++;
        if ({sh_vld, res_vld, occ} !== {1'b0, 1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL midrst_E: got sh_vld=%b res_vld=%b occ=%0d expected 0 0 1",
                     sh_vld, res_vld, occ);
        end
        @(negedge clk);  // after E+1
        n_cmp++;
        if ({sh_vld, sh_in, sh_n, sh_lr, res_vld} !== {1'b1, 8'hA5, 3'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midrst_E1: got vld=%b in=%h n=%0d lr=%b res_vld=%b expected 1 a5 2 0 0",
                     sh_vld, sh_in, sh_n, sh_lr, res_vld);
        end
        @(negedge clk);  // after E+2
        n_cmp++;
        if (exp_q.size() == 0 || res_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_E2: got res_vld=%b expected 1", res_vld);
        end else begin
            exp = exp_q.pop_front();
            if (res_data !== exp) begin
                n_fail++;
                $display("FAIL midrst_E2: got %h expected %h", res_data, exp);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        cmd_vld  = 1'b0;
        cmd_data = '0;
        cmd_n    = '0;
        cmd_lr   = 1'b0;
        res_rdy  = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure_fill();
        test_drain();
        test_wrap();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
